// File: rtl/layer0_input_assembler.sv
// Serial feature quantiser and packer feeding the layer0 neuron bank.
// Optional saturation counter built when LAYER0_IN_SAT_CNT_EN is defined.
module layer0_input_assembler #(
  parameter int NUM_FEAT = 49,
  parameter int FEAT_W   = 16,
  parameter int IN_BITS  = 2,
  parameter int Q_SHIFT  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [FEAT_W-1:0]            s_data,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_FEAT*IN_BITS-1:0]  m_data,
  output logic                         frame_err
`ifdef LAYER0_IN_SAT_CNT_EN
  ,
  output logic [15:0]                  sat_cnt
`endif
);

  localparam int VEC_W = NUM_FEAT * IN_BITS;
  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic signed [FEAT_W-1:0] QMAX = FEAT_W'((1 << IN_BITS) - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx;
  logic [VEC_W-1:0]          asm_buf, asm_nxt;
  logic signed [FEAT_W-1:0]  v;
  logic [IN_BITS-1:0]        q;
  logic                      neg, over;
  logic                      accept, at_last, complete, slot_free, drain_hold;

  // Quantiser: shift, then clamp into [0, 2^IN_BITS-1]
  always_comb begin
    v    = $signed(s_data) >>> Q_SHIFT;
    neg  = (v < 0);
    over = (v > QMAX);
    q    = v[IN_BITS-1:0];
    if (neg)       q = '0;
    else if (over) q = '1;
  end

  assign s_ready    = rst_n && (state == FILL);
  assign accept     = s_valid && s_ready;
  assign at_last    = (idx == LAST_IDX);
  assign complete   = accept && at_last;
  assign slot_free  = !m_valid || m_ready;
  assign drain_hold = (state == HOLD) && m_valid && m_ready;

  // Buffer with the current word merged in, so a completing vector can load directly
  always_comb begin
    asm_nxt = asm_buf;
    for (int i = 0; i < NUM_FEAT; i++)
      if (accept && idx == IDX_W'(i)) asm_nxt[i*IN_BITS +: IN_BITS] = q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (complete && !slot_free) state_nxt = HOLD;
      HOLD:    if (drain_hold)             state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      asm_buf   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= accept && (at_last ? !s_last : s_last);
      if (accept) begin
        asm_buf <= asm_nxt;
        idx     <= (at_last || s_last) ? '0 : idx + 1'b1;
      end
      if (complete && slot_free) begin
        m_data  <= asm_nxt;
        m_valid <= 1'b1;
      end else if (drain_hold) begin
        m_data  <= asm_buf;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef LAYER0_IN_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (accept && (neg || over) && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule
